// File: rtl/bagging_pkg.sv
// rtl/bagging_pkg.sv - shared types, prediction constants and width helpers for the bagging ensemble
package bagging_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    VOTE  = 2'd3
  } state_t;

  localparam logic signed [1:0] PRED_POS = 2'sb01;
  localparam logic signed [1:0] PRED_NEG = 2'sb11;

  // Headroom for NUM_FEATURES weights plus the bias, all at their extreme value.
  function automatic int acc_width(input int w_width, input int num_features);
    return w_width + $clog2(num_features + 1) + 1;
  endfunction

  function automatic int feat_idx_width(input int num_features);
    return (num_features > 1) ? $clog2(num_features) : 1;
  endfunction

endpackage

// File: rtl/bagging_learner.sv
// rtl/bagging_learner.sv - one linear learner: weight/bias store, masked accumulator, sign vote
module bagging_learner
  import bagging_pkg::*;
#(
  parameter int NUM_FEATURES = 30,
  parameter int W_WIDTH      = 9,
  parameter int ADDR_W       = $clog2(NUM_FEATURES + 1),
  parameter int ACC_WIDTH    = acc_width(W_WIDTH, NUM_FEATURES),
  parameter int IDX_W        = feat_idx_width(NUM_FEATURES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic signed [W_WIDTH-1:0] wr_data,
  input  logic                      clear,
  input  logic                      accum_en,
  input  logic                      feature,
  input  logic [IDX_W-1:0]          idx,
  input  logic                      final_en,
  output logic                      vote
);

  localparam int EXT = ACC_WIDTH - W_WIDTH;

  logic signed [W_WIDTH-1:0]   weight_mem [NUM_FEATURES];
  logic signed [W_WIDTH-1:0]   bias_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] total;
  logic signed [W_WIDTH-1:0]   w_cur;

  // Storage deliberately has no reset so loaded models survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_addr == ADDR_W'(NUM_FEATURES)) begin
        bias_q <= wr_data;
      end else begin
        weight_mem[wr_addr[IDX_W-1:0]] <= wr_data;
      end
    end
  end

  assign w_cur = weight_mem[idx];
  assign w_ext = {{EXT{w_cur[W_WIDTH-1]}}, w_cur};
  assign b_ext = {{EXT{bias_q[W_WIDTH-1]}}, bias_q};
  assign total = acc_q + b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (accum_en && feature) begin
      acc_q <= acc_q + w_ext;
    end
  end

  // A zero total counts as a positive vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      vote <= 1'b0;
    end else if (final_en) begin
      vote <= ~total[ACC_WIDTH-1];
    end
  end

endmodule

// File: rtl/bagging_ensemble_n.sv
// rtl/bagging_ensemble_n.sv - N-learner bagging classifier with majority vote; BAGGING_VOTE_DETAIL_EN adds vote_bits/vote_count
module bagging_ensemble_n
  import bagging_pkg::*;
#(
  parameter int NUM_LEARNERS = 3,
  parameter int NUM_FEATURES = 30,
  parameter int W_WIDTH      = 9,
  parameter int ADDR_W       = $clog2(NUM_FEATURES + 1),
  parameter int LRN_W        = (NUM_LEARNERS > 1) ? $clog2(NUM_LEARNERS) : 1,
  parameter int ACC_WIDTH    = acc_width(W_WIDTH, NUM_FEATURES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [LRN_W-1:0]          wr_learner,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic signed [W_WIDTH-1:0] wr_data,
  output logic                      wr_ready,
  input  logic                      start,
  input  logic [NUM_FEATURES-1:0]   in_data,
  output logic                      busy,
  output logic                      done,
  output logic signed [1:0]         predict
`ifdef BAGGING_VOTE_DETAIL_EN
  ,
  output logic [NUM_LEARNERS-1:0]   vote_bits,
  output logic [LRN_W:0]            vote_count
`endif
);

  localparam int IDX_W = feat_idx_width(NUM_FEATURES);

  state_t                    state_q;
  state_t                    state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [NUM_FEATURES-1:0]   data_q;
  logic [NUM_LEARNERS-1:0]   votes;
  logic [LRN_W:0]            vote_cnt;
  logic signed [1:0]         vote_pred;
  logic signed [1:0]         predict_q;
  logic                      wr_commit;
  logic                      clear_acc;
  logic                      accum_en;
  logic                      final_en;

  assign wr_ready  = (state_q == IDLE) && !start;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == VOTE);
  assign wr_commit = wr_en && wr_ready
                     && (32'(wr_learner) < NUM_LEARNERS)
                     && (32'(wr_addr) <= NUM_FEATURES);

  always_comb begin
    state_d   = state_q;
    clear_acc = 1'b0;
    accum_en  = 1'b0;
    final_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear_acc = 1'b1;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        accum_en = 1'b1;
        if (idx_q == IDX_W'(NUM_FEATURES - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        final_en = 1'b1;
        state_d  = VOTE;
      end
      VOTE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (clear_acc) begin
      idx_q <= '0;
    end else if (accum_en) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // The sample is captured at start so later in_data changes cannot leak in.
  always_ff @(posedge clk) begin
    if (clear_acc) begin
      data_q <= in_data;
    end
  end

  for (genvar n = 0; n < NUM_LEARNERS; n++) begin : g_learner
    bagging_learner #(
      .NUM_FEATURES (NUM_FEATURES),
      .W_WIDTH      (W_WIDTH),
      .ADDR_W       (ADDR_W),
      .ACC_WIDTH    (ACC_WIDTH),
      .IDX_W        (IDX_W)
    ) u_learner (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_commit && (wr_learner == LRN_W'(n))),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .clear    (clear_acc),
      .accum_en (accum_en),
      .feature  (data_q[idx_q]),
      .idx      (idx_q),
      .final_en (final_en),
      .vote     (votes[n])
    );
  end

  always_comb begin
    vote_cnt = '0;
    for (int n = 0; n < NUM_LEARNERS; n++) begin
      vote_cnt = vote_cnt + {{LRN_W{1'b0}}, votes[n]};
    end
  end

  assign vote_pred = (32'(vote_cnt) > (NUM_LEARNERS / 2)) ? PRED_POS : PRED_NEG;

  // The fresh result is shown during the done cycle, then held from the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      predict_q <= 2'b00;
    end else if (state_q == VOTE) begin
      predict_q <= vote_pred;
    end
  end

  assign predict = (state_q == VOTE) ? vote_pred : predict_q;

`ifdef BAGGING_VOTE_DETAIL_EN
  logic [NUM_LEARNERS-1:0] vote_bits_q;
  logic [LRN_W:0]          vote_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_bits_q  <= '0;
      vote_count_q <= '0;
    end else if (state_q == VOTE) begin
      vote_bits_q  <= votes;
      vote_count_q <= vote_cnt;
    end
  end

  assign vote_bits  = (state_q == VOTE) ? votes : vote_bits_q;
  assign vote_count = (state_q == VOTE) ? vote_cnt : vote_count_q;
`endif

endmodule

// File: tb/tb_bagging_ensemble_n.sv
// tb/tb_bagging_ensemble_n.sv - self-checking bench for bagging_ensemble_n (3x30 and 5x8 instances)
module tb_bagging_ensemble_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  // Instance A: default 3 learners x 30 features
  logic        a_wr_en, a_wr_ready, a_start, a_busy, a_done;
  logic [1:0]  a_wr_l;
  logic [4:0]  a_wr_a;
  logic [8:0]  a_wr_d;
  logic [29:0] a_in;
  logic [1:0]  a_pred;
  // Instance B: 5 learners x 8 features
  logic        b_wr_en, b_wr_ready, b_start, b_busy, b_done;
  logic [2:0]  b_wr_l;
  logic [3:0]  b_wr_a;
  logic [8:0]  b_wr_d;
  logic [7:0]  b_in;
  logic [1:0]  b_pred;
`ifdef BAGGING_VOTE_DETAIL_EN
  logic [2:0]  a_vbits;
  logic [2:0]  a_vcnt;
  logic [4:0]  b_vbits;
  logic [3:0]  b_vcnt;
`endif

  bagging_ensemble_n u_dut (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_learner(a_wr_l), .wr_addr(a_wr_a),
    .wr_data(a_wr_d), .wr_ready(a_wr_ready), .start(a_start), .in_data(a_in),
    .busy(a_busy), .done(a_done), .predict(a_pred)
`ifdef BAGGING_VOTE_DETAIL_EN
    , .vote_bits(a_vbits), .vote_count(a_vcnt)
`endif
  );

  bagging_ensemble_n #(.NUM_LEARNERS(5), .NUM_FEATURES(8)) u_dut5 (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_learner(b_wr_l), .wr_addr(b_wr_a),
    .wr_data(b_wr_d), .wr_ready(b_wr_ready), .start(b_start), .in_data(b_in),
    .busy(b_busy), .done(b_done), .predict(b_pred)
`ifdef BAGGING_VOTE_DETAIL_EN
    , .vote_bits(b_vbits), .vote_count(b_vcnt)
`endif
  );

  // Behavioural model: weights per unit/learner, bias kept at index num_features.
  int          mw    [2][5][31];
  int          mnl   [2] = '{3, 5};
  int          mnf   [2] = '{30, 8};
  bit          mbusy [2];
  int          mrem  [2];
  logic [29:0] mlat  [2];
  logic [1:0]  mpred [2];
  logic [4:0]  mvbits[2];
  int          mvcnt [2];

  task automatic model_vote(input int u);
    int cnt;
    logic [4:0] vb;
    cnt = 0;
    vb  = '0;
    for (int l = 0; l < mnl[u]; l++) begin
      int s;
      s = mw[u][l][mnf[u]];
      for (int i = 0; i < mnf[u]; i++) if (mlat[u][i]) s += mw[u][l][i];
      if (s >= 0) begin
        cnt++;
        vb[l] = 1'b1;
      end
    end
    mpred[u]  = (cnt > mnl[u] / 2) ? 2'b01 : 2'b11;
    mvbits[u] = vb;
    mvcnt[u]  = cnt;
  endtask

  task automatic model_step(input int u, input logic r, input logic st, input logic we,
                            input int wl, input int wa, input int wd, input logic [29:0] din);
    if (r) begin
      mbusy[u] = 1'b0; mpred[u] = 2'b00; mvbits[u] = '0; mvcnt[u] = 0;
    end else if (!mbusy[u]) begin
      if (we && !st && wl < mnl[u] && wa <= mnf[u]) mw[u][wl][wa] = wd;
      if (st) begin
        mbusy[u] = 1'b1; mrem[u] = mnf[u] + 1; mlat[u] = din;
      end
    end else if (mrem[u] == 0) begin
      mbusy[u] = 1'b0;
    end else begin
      mrem[u]--;
      if (mrem[u] == 0) model_vote(u);
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst, a_start, a_wr_en, int'(a_wr_l), int'(a_wr_a), int'($signed(a_wr_d)), a_in);
    model_step(1, rst, b_start, b_wr_en, int'(b_wr_l), int'(b_wr_a), int'($signed(b_wr_d)), {22'b0, b_in});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_busy",  a_busy,  mbusy[0]);
      chk("a_done",  a_done,  mbusy[0] && mrem[0] == 0);
      chk("a_ready", a_wr_ready, !mbusy[0] && !a_start);
      chk("a_pred",  a_pred,  mpred[0]);
      chk("b_busy",  b_busy,  mbusy[1]);
      chk("b_done",  b_done,  mbusy[1] && mrem[1] == 0);
      chk("b_ready", b_wr_ready, !mbusy[1] && !b_start);
      chk("b_pred",  b_pred,  mpred[1]);
`ifdef BAGGING_VOTE_DETAIL_EN
      chk("a_vbits", a_vbits, mvbits[0][2:0]);
      chk("a_vcnt",  a_vcnt,  mvcnt[0]);
      chk("b_vbits", b_vbits, mvbits[1]);
      chk("b_vcnt",  b_vcnt,  mvcnt[1]);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input int l, input int a, input int d);
    a_wr_en = 1'b1; a_wr_l = 2'(l); a_wr_a = 5'(a); a_wr_d = 9'(d);
    step();
    a_wr_en = 1'b0;
  endtask

  task automatic a_load(input int w, input int b);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 30; i++) a_write(l, i, w);
      a_write(l, 30, b);
    end
  endtask

  task automatic b_write(input int l, input int a, input int d);
    b_wr_en = 1'b1; b_wr_l = 3'(l); b_wr_a = 4'(a); b_wr_d = 9'(d);
    step();
    b_wr_en = 1'b0;
  endtask

  // Start, scramble in_data afterwards, wait for done and pin latency and result.
  task automatic a_run(input string name, input logic [29:0] din, input logic [1:0] exp_pred);
    int cyc;
    a_in = din; a_start = 1'b1;
    step();
    a_start = 1'b0; a_in = ~din;
    cyc = 1;
    while (!a_done && cyc < 100) begin
      step();
      cyc++;
    end
    chk({name, "_latency"}, cyc, 32);
    chk({name, "_pred"}, a_pred, exp_pred);
    step();
  endtask

  task automatic b_run(input string name, input logic [7:0] din, input logic [1:0] exp_pred);
    int cyc;
    b_in = din; b_start = 1'b1;
    step();
    b_start = 1'b0;
    cyc = 1;
    while (!b_done && cyc < 100) begin
      step();
      cyc++;
    end
    chk({name, "_latency"}, cyc, 10);
    chk({name, "_pred"}, b_pred, exp_pred);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst = 1'b1;
    a_wr_en = 0; a_wr_l = 0; a_wr_a = 0; a_wr_d = 0; a_start = 0; a_in = '0;
    b_wr_en = 0; b_wr_l = 0; b_wr_a = 0; b_wr_d = 0; b_start = 0; b_in = '0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", a_busy, 1'b0);
    chk("reset_done", a_done, 1'b0);
    chk("reset_pred", a_pred, 2'b00);
    chk("reset_ready", a_wr_ready, 1'b1);

    // Every learner: 15 ones * 1 - 10 = +5
    a_load(1, -10);
    a_run("all_pos", 30'h00007FFF, 2'b01);
`ifdef BAGGING_VOTE_DETAIL_EN
    chk("all_pos_vcnt", a_vcnt, 3);
`endif
    a_write(2, 30, -100);
    a_run("one_neg", 30'h00007FFF, 2'b01);
`ifdef BAGGING_VOTE_DETAIL_EN
    chk("one_neg_vbits", a_vbits, 3'b011);
`endif

    // Busy: second start and a write of learner 1 bias must both be ignored
    a_in = 30'h00007FFF; a_start = 1'b1;
    step();
    a_start = 1'b0;
    repeat (5) step();
    a_start = 1'b1; a_wr_en = 1'b1; a_wr_l = 2'd1; a_wr_a = 5'd30; a_wr_d = 9'(-100);
    chk("busy_ready", a_wr_ready, 1'b0);
    step();
    a_start = 1'b0; a_wr_en = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_done) ndone++;
      step();
    end
    chk("busy_done_once", ndone, 1);
    a_run("busy_readback", 30'h00007FFF, 2'b01);

    // Out-of-range addresses and learner select are dropped
    a_write(0, 31, -100);
    a_write(3, 30, -100);
    a_run("dropped_wr", 30'h00007FFF, 2'b01);

    a_write(1, 30, -100);
    a_run("two_neg", 30'h00007FFF, 2'b11);

    // Sum exactly zero votes +1
    for (int l = 0; l < 3; l++) a_write(l, 30, -15);
    a_run("zero_sum", 30'h3FFF8000, 2'b01);

    a_load(255, 255);
    a_run("max_sum", 30'h3FFFFFFF, 2'b01);
    a_load(-256, -256);
    a_run("min_sum", 30'h3FFFFFFF, 2'b11);

    // Reset partway through ACCUM, then rerun with retained weights
    a_load(1, -10);
    a_run("pre_rst", 30'h0000FFFF, 2'b01);
    a_in = 30'h0000FFFF; a_start = 1'b1;
    step();
    a_start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_pred", a_pred, 2'b00);
    repeat (35) step();
    a_run("post_rst", 30'h0000FFFF, 2'b01);

    // 5 learners x 8 features: 8 ones, biases 0 give +8, -100 give -92
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 8; i++) b_write(l, i, 1);
      b_write(l, 8, 0);
    end
    b_run("b_all_pos", 8'hFF, 2'b01);
    for (int l = 2; l < 5; l++) b_write(l, 8, -100);
    b_run("b_three_neg", 8'hFF, 2'b11);
    b_write(4, 8, 0);
    b_run("b_two_neg", 8'hFF, 2'b01);

    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bagging_ensemble_n.md
Name: bagging_ensemble_n

Overview:
- Parametrised successor to the fixed three-learner binary-weight bagging classifier.
- Holds NUM_LEARNERS linear learners, each with NUM_FEATURES signed weights and one bias, loaded through a single write port.
- On start, the block streams a latched binary feature vector through all learners in parallel, takes each learner's sign, and issues a majority-vote prediction of +1 or -1.
- Sits between the weight-loading controller and the downstream result collector.

Parameters:
- NUM_LEARNERS, 3, number of learners; must be odd and at least 1.
- NUM_FEATURES, 30, features per sample.
- W_WIDTH, 9, signed weight and bias width.
- ADDR_W, $clog2(NUM_FEATURES+1), weight/bias address width (derived).
- LRN_W, max(1,$clog2(NUM_LEARNERS)), learner select width (derived).
- ACC_WIDTH, W_WIDTH+$clog2(NUM_FEATURES+1)+1, accumulator width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  weight/bias write strobe
- wr_learner  in  LRN_W  target learner
- wr_addr  in  ADDR_W  0..NUM_FEATURES-1 selects a weight; NUM_FEATURES selects the bias
- wr_data  in  W_WIDTH  signed value
- wr_ready  out  1  write accepted this cycle
- start  in  1  begin inference
- in_data  in  NUM_FEATURES  binary feature vector, bit i = feature i
- busy  out  1  inference in progress
- done  out  1  one-cycle result strobe
- predict  out  2  signed result: 2'sb01 = +1, 2'sb11 = -1

Behaviour:
- Reset state: state=IDLE, busy=0, done=0, predict=2'b00, wr_ready=1, accumulators=0.
- Weight and bias storage is not cleared by reset; contents are retained across reset.
- wr_ready = (state==IDLE) && !start.
- A write is committed when wr_en && wr_ready. Writes with wr_ready=0, wr_learner>=NUM_LEARNERS, or wr_addr>NUM_FEATURES are silently dropped.
- FSM states: IDLE, ACCUM, FINAL, VOTE.
- IDLE: on start, latch in_data, clear all accumulators, set index=0, go to ACCUM. busy=1 from the next cycle.
- ACCUM: one feature per cycle. Each learner computes acc += feature[index] ? sign-extended weight[index] : 0. After index=NUM_FEATURES-1, go to FINAL. Duration: NUM_FEATURES cycles.
- FINAL: each learner computes acc + sign-extended bias and registers a vote: +1 if the sum >= 0 (zero counts as +1), else -1.
- VOTE: count the +1 votes. predict=+1 if the count > NUM_LEARNERS/2, else -1. Ties are impossible because NUM_LEARNERS is odd. done=1 for exactly this cycle, then return to IDLE with busy=0.
- Latency: with start sampled at cycle 0, done is asserted at cycle NUM_FEATURES+2 (32 for default parameters).
- predict holds its value until the next done, or until reset.
- start while busy is ignored. in_data changes after the start cycle have no effect.
- All arithmetic is signed two's complement. ACC_WIDTH guarantees no overflow for any weights and bias.
- Reset mid-operation (any state): back to IDLE within the same clock edge, busy=0, no done pulse, predict=2'b00.

Optional Feature:
- Macro: BAGGING_VOTE_DETAIL_EN.
- When defined, two extra outputs are present:
  - vote_bits [NUM_LEARNERS-1:0]: bit n=1 when learner n voted +1.
  - vote_count [LRN_W:0]: number of +1 votes.
- Both are registered on the VOTE cycle, reset to 0, and hold their values like predict.
- When the macro is undefined, these ports and their registers are absent. predict and done behaviour is identical in both builds.

Decomposition:
- Package bagging_pkg holds:
  - the state enum (IDLE, ACCUM, FINAL, VOTE);
  - the prediction constants PRED_POS=2'sb01 and PRED_NEG=2'sb11;
  - an accumulator-width function.
- Sub-module bagging_learner: one weight array plus bias register, masked accumulator and sign vote. Instantiated NUM_LEARNERS times in a generate loop. The top level owns the FSM, the feature index, the in_data latch and the majority vote.

Test Plan:
- Load all weights=+1 and all biases=-10; in_data with 15 ones; start at cycle 0 -> every sum = +5, done at cycle 32, predict=2'sb01, vote_count=3.
- Learner 2 bias=-100, others as above -> votes 1,1,0; predict=+1, vote_bits=3'b011. Then learners 1 and 2 bias=-100 -> predict=2'sb11.
- Boundary: weights +1, bias -15, 15 ones -> sum=0 -> every vote +1, predict=+1. Extremes: all weights=+255, bias=+255, in_data all ones -> sum=7905, predict=+1. All weights=-256, bias=-256 -> sum=-7936, predict=-1, no wraparound.
- Assert rst at cycle 10 of ACCUM -> busy=0 next cycle, no done, predict=0. Restart with the same in_data -> same result as before reset, confirming weights were retained.
- start pulsed again during ACCUM, plus wr_en while busy -> start ignored, wr_ready=0, weight unchanged on readback run; done pulses exactly once.
- NUM_LEARNERS=5, NUM_FEATURES=8 build: three learners forced to -1 -> predict=-1 at cycle 10.
